inst_buffer: RTL and testbench
==============================

Name: inst_buffer

Overview:
Circular instruction queue between fetch and decode/dispatch.
- Accepts up to IN_WIDTH fetched instructions per cycle, all-or-nothing.
- Presents up to OUT_WIDTH oldest instructions in program order to the decoders.
- Decouples fetch stalls from dispatch stalls; flushed on squash (branch mispredict).

Parameters:
DEPTH, 8, number of entries; power of 2, DEPTH >= max(IN_WIDTH, OUT_WIDTH)
IN_WIDTH, 2, fetch slots per cycle
OUT_WIDTH, 2, decode slots per cycle

Ports:
clock  in  1  system clock; one clock domain; all state updates on rising edge
reset  in  1  synchronous, active-high reset
squash  in  1  flush all entries; sampled at clock edge
in_valid  in  IN_WIDTH  per-slot valid; must be contiguous from slot 0
in_inst  in  IN_WIDTH x 32  fetched instruction words (INST)
in_pc  in  IN_WIDTH x 32  PC of each slot
in_npc  in  IN_WIDTH x 32  predicted next PC of each slot
in_ready  out  1  buffer will accept this cycle's in_valid group
out_req  in  $clog2(OUT_WIDTH+1)  number of slots consumer takes this cycle
out_valid  out  OUT_WIDTH  thermometer; slot i valid iff i < count
out_inst  out  OUT_WIDTH x 32  instruction, oldest in slot 0
out_pc  out  OUT_WIDTH x 32  PC per slot
out_npc  out  OUT_WIDTH x 32  predicted NPC per slot
count  out  $clog2(DEPTH+1)  occupied entries (registered)

Behaviour:
- State: head and tail pointers, each log2(DEPTH) bits, wrapping modulo DEPTH; separate registered count.
- Reset (reset=1 at edge): head=0, tail=0, count=0. Consequently out_valid=0 and in_ready=1. Storage contents are don't-care.
- in_ready = (DEPTH - count) >= IN_WIDTH. Depends on registered count only; same-cycle pops are not credited. No combinational path from in_valid or out_req.
- Push:
  - If in_ready, n_in = popcount(in_valid) entries are written at tail..tail+n_in-1 with wrap; tail advances by n_in.
  - If !in_ready, the whole group is dropped. Fetch must hold it.
- Pop:
  - n_out = min(out_req, count, OUT_WIDTH); out_req above OUT_WIDTH clamps.
  - head advances by n_out. Popping beyond count never underflows.
- Outputs combinational from storage at head+i (wrap). Latency push-to-visible is 1 cycle.
- Invalid output slots drive out_inst = NOP (32'h00000013), out_pc = 0, out_npc = 0, so the downstream decoder sees a NOP.
- Simultaneous push and pop: count_next = count + n_in - n_out. Legal at any occupancy, including full (in_ready=0, pop only) and empty (push only, n_out=0).
- Squash, or reset, has priority over push/pop in the same cycle. Next cycle: head=tail=0, count=0, and that cycle's push/pop are discarded.
- Non-contiguous in_valid is a protocol violation. A simulation-only assertion fires; RTL behaviour is undefined.
- Elaboration-time check fails if DEPTH is not a power of 2 or is less than IN_WIDTH or OUT_WIDTH.

Optional Feature:
INST_BUFFER_BYPASS_EN
- Defined:
  - When count==0 and squash==0, out slot i (i < min(IN_WIDTH, OUT_WIDTH)) shows in slot i combinationally, and out_valid[i]=in_valid[i] & in_ready.
  - Bypassed slots consumed by out_req are not written to storage; the remainder are enqueued.
  - Push-to-visible latency is 0 when empty.
  - Adds a combinational path in_* -> out_*.
- Undefined: no bypass; outputs depend only on registered state; latency always 1.

Decomposition:
- Shared package / sys_defs.svh:
  - IB_ENTRY packed struct {INST inst; ADDR pc; ADDR npc;}.
  - NOP constant, reused from the existing definition.
- Sub-module ib_storage: DEPTH x IB_ENTRY register array with IN_WIDTH wrapped write ports and OUT_WIDTH wrapped read ports, taking base pointers and per-port enables.
- inst_buffer keeps pointers, count, handshake and bypass logic.

Test Plan:
DEPTH=8, IN_WIDTH=2, OUT_WIDTH=2.
1. Reset asserted mid-operation at count=5 -> next cycle count=0, out_valid=2'b00, in_ready=1, out_inst=NOP in both slots.
2. Push in_valid=2'b11, pc={0x4,0x0}, out_req=0 -> next cycle count=2, out_valid=2'b11, out_pc[0]=0x0, out_pc[1]=0x4.
3. Push 2 per cycle for 4 cycles, out_req=0 -> count=8, in_ready=0. A fifth group held 3 cycles is dropped and count stays 8. Then out_req=2 -> count=6, in_ready=1.
4. Wrap order: from count=6, push 2 / pop 2 per cycle for 10 cycles with PCs incrementing by 4 -> count stays 6 and popped out_pc sequence is strictly +4 across pointer wrap.
5. Squash at count=5 with in_valid=2'b11 and out_req=2 -> next cycle count=0, out_valid=2'b00; pushed entries never appear.
6. count=1, out_req=2 -> count=0 next cycle, no underflow. With INST_BUFFER_BYPASS_EN: at count=0, push 2'b11 with out_req=1 -> slot 0 visible the same cycle and consumed, count=1 next cycle holding the in slot 1 entry.

Source files
------------

// File: rtl/inst_buffer_pkg.sv
// Shared types for the instruction buffer: the per-entry payload and the NOP word
// that empty decode slots carry.
package inst_buffer_pkg;

  typedef logic [31:0] inst_t;
  typedef logic [31:0] addr_t;

  typedef struct packed {
    inst_t inst;
    addr_t pc;
    addr_t npc;
  } ib_entry_t;

  localparam inst_t NOP = 32'h0000_0013;

endpackage

// File: rtl/ib_storage.sv
// DEPTH-entry register file with IN_WIDTH write ports and OUT_WIDTH read ports,
// each port addressed as base pointer plus slot index, wrapping modulo DEPTH.
module ib_storage
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 2,
  localparam int PTR_W    = $clog2(DEPTH)
) (
  input  logic                            clock,
  input  logic [PTR_W-1:0]                wr_base,
  input  logic [IN_WIDTH-1:0]             wr_en,
  input  ib_entry_t [IN_WIDTH-1:0]        wr_data,
  input  logic [PTR_W-1:0]                rd_base,
  output ib_entry_t [OUT_WIDTH-1:0]       rd_data
);

  ib_entry_t mem [DEPTH];

  // NOTE: the array has no reset; pointers and count decide validity, so clearing
  // storage would only cost flops and reset fan-out.
  always_ff @(posedge clock) begin
    for (int j = 0; j < IN_WIDTH; j++) begin
      if (wr_en[j]) mem[wr_base + PTR_W'(j)] <= wr_data[j];
    end
  end

  for (genvar i = 0; i < OUT_WIDTH; i++) begin : g_rd
    assign rd_data[i] = mem[rd_base + PTR_W'(i)];
  end

endmodule

// File: rtl/inst_buffer.sv
// Circular fetch-to-decode instruction queue: all-or-nothing group push, up to
// OUT_WIDTH in-order pops, squash flush. Define INST_BUFFER_BYPASS_EN for empty-queue bypass.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 2,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(DEPTH + 1),
  localparam int REQ_W    = $clog2(OUT_WIDTH + 1)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            squash,
  input  logic [IN_WIDTH-1:0]             in_valid,
  input  logic [IN_WIDTH-1:0][31:0]       in_inst,
  input  logic [IN_WIDTH-1:0][31:0]       in_pc,
  input  logic [IN_WIDTH-1:0][31:0]       in_npc,
  output logic                            in_ready,
  input  logic [REQ_W-1:0]                out_req,
  output logic [OUT_WIDTH-1:0]            out_valid,
  output logic [OUT_WIDTH-1:0][31:0]      out_inst,
  output logic [OUT_WIDTH-1:0][31:0]      out_pc,
  output logic [OUT_WIDTH-1:0][31:0]      out_npc,
  output logic [CNT_W-1:0]                count
);

  if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < IN_WIDTH || DEPTH < OUT_WIDTH) begin : g_bad_cfg
    $error("inst_buffer: DEPTH must be a power of 2 and >= IN_WIDTH, OUT_WIDTH");
  end

  logic [PTR_W-1:0]          head, tail;
  logic [CNT_W-1:0]          n_in, n_push, n_pop, n_byp, req_clamp;
  logic [IN_WIDTH-1:0]       wr_en;
  ib_entry_t [IN_WIDTH-1:0]  wr_data;
  ib_entry_t [OUT_WIDTH-1:0] rd_data;

  // Free space from the registered count only, so pops never combinationally enable pushes.
  assign in_ready  = int'(count) <= DEPTH - IN_WIDTH;
  assign req_clamp = (int'(out_req) > OUT_WIDTH) ? CNT_W'(OUT_WIDTH) : CNT_W'(out_req);
  assign n_pop     = (req_clamp < count) ? req_clamp : count;
  assign n_push    = in_ready ? n_in - n_byp : '0;

  always_comb begin
    n_in = '0;
    for (int i = 0; i < IN_WIDTH; i++) n_in = n_in + CNT_W'(in_valid[i]);
  end

`ifdef INST_BUFFER_BYPASS_EN
  localparam int BYP_W = (IN_WIDTH < OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
  logic             bypass;
  logic [CNT_W-1:0] n_avail;

  assign bypass  = (count == '0) && !squash;
  assign n_avail = (n_in < CNT_W'(BYP_W)) ? n_in : CNT_W'(BYP_W);
  assign n_byp   = !bypass ? '0 : (req_clamp < n_avail) ? req_clamp : n_avail;
`else
  assign n_byp   = '0;
`endif

  // Consumed bypass slots are skipped; shifting the base back keeps the rest landing at tail.
  always_comb begin
    for (int j = 0; j < IN_WIDTH; j++) begin
      wr_data[j] = '{inst: in_inst[j], pc: in_pc[j], npc: in_npc[j]};
      wr_en[j]   = in_ready && !squash && in_valid[j] && (CNT_W'(j) >= n_byp);
    end
  end

  ib_storage #(
    .DEPTH    (DEPTH),
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_storage (
    .clock  (clock),
    .wr_base(tail - PTR_W'(n_byp)),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .rd_base(head),
    .rd_data(rd_data)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(n_pop);
      tail  <= tail + PTR_W'(n_push);
      count <= count + n_push - n_pop;
    end
  end

  // NOTE: every output is given a value before any condition, so no latch is inferred.
  always_comb begin
    ib_entry_t e;
    logic      v;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      e = rd_data[i];
      v = i < int'(count);
`ifdef INST_BUFFER_BYPASS_EN
      if (bypass && i < BYP_W) begin
        e = '{inst: in_inst[i], pc: in_pc[i], npc: in_npc[i]};
        v = in_valid[i] & in_ready;
      end
`endif
      out_valid[i] = v;
      out_inst[i]  = v ? e.inst : NOP;
      out_pc[i]    = v ? e.pc   : '0;
      out_npc[i]   = v ? e.npc  : '0;
    end
  end

  a_in_valid_contiguous : assert property (@(posedge clock) disable iff (reset)
    ((in_valid & (in_valid + IN_WIDTH'(1))) == '0));

endmodule

// File: tb/tb_inst_buffer.sv
// Randomized bench for inst_buffer, checked cycle by cycle against a queue model of
// the buffer contents; compile with INST_BUFFER_BYPASS_EN to model the bypass build.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int DEPTH     = 8;
  localparam int IN_WIDTH  = 2;
  localparam int OUT_WIDTH = 2;
  localparam int CNT_W     = $clog2(DEPTH + 1);
  localparam int REQ_W     = $clog2(OUT_WIDTH + 1);
  localparam int BYP_W     = (IN_WIDTH < OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;

  logic                       clock = 1'b0;
  logic                       reset, squash;
  logic [IN_WIDTH-1:0]        in_valid;
  logic [IN_WIDTH-1:0][31:0]  in_inst, in_pc, in_npc;
  logic                       in_ready;
  logic [REQ_W-1:0]           out_req;
  logic [OUT_WIDTH-1:0]       out_valid;
  logic [OUT_WIDTH-1:0][31:0] out_inst, out_pc, out_npc;
  logic [CNT_W-1:0]           count;

  always #5 clock = ~clock;

  inst_buffer #(.DEPTH(DEPTH), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_npc(in_npc),
    .in_ready(in_ready), .out_req(out_req),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_npc(out_npc),
    .count(count)
  );

  ib_entry_t   q[$];
  logic [31:0] fetch_pc = '0;
  logic [31:0] seen_pc0;
  int          checks = 0;
  int          passes = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One cycle: drive at negedge, compare outputs against the model, then advance the model.
  task automatic step(input bit rst, input bit sq, input int n, input int req);
    bit        exp_ready, byp, v;
    ib_entry_t e;
    int        take, k;
    @(negedge clock);
    reset   = rst;
    squash  = sq;
    out_req = REQ_W'(req);
    for (int i = 0; i < IN_WIDTH; i++) begin
      in_valid[i] = i < n;
      in_inst[i]  = $urandom;
      in_pc[i]    = fetch_pc + 32'(4 * i);
      in_npc[i]   = fetch_pc + 32'(4 * i + 4);
    end
    #1;
    exp_ready = (DEPTH - q.size()) >= IN_WIDTH;
    byp = 1'b0;
`ifdef INST_BUFFER_BYPASS_EN
    byp = (q.size() == 0) && !sq;
`endif
    check("count", 32'(count), 32'(q.size()));
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    seen_pc0 = out_pc[0];
    for (int i = 0; i < OUT_WIDTH; i++) begin
      v = i < q.size();
      e = v ? q[i] : '{inst: NOP, pc: '0, npc: '0};
      if (byp && i < BYP_W) begin
        v = (i < n) && exp_ready;
        e = '{inst: in_inst[i], pc: in_pc[i], npc: in_npc[i]};
      end
      if (!v) e = '{inst: NOP, pc: '0, npc: '0};
      check($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(v));
      check($sformatf("out_inst[%0d]", i), out_inst[i], e.inst);
      check($sformatf("out_pc[%0d]", i), out_pc[i], e.pc);
      check($sformatf("out_npc[%0d]", i), out_npc[i], e.npc);
    end
    @(posedge clock);
    if (rst || sq) begin
      q.delete();
    end else begin
      take = (req > OUT_WIDTH) ? OUT_WIDTH : req;
      if (byp) begin
        k = (n < BYP_W) ? n : BYP_W;
        k = (take < k) ? take : k;
        for (int i = k; i < n; i++) q.push_back('{inst: in_inst[i], pc: in_pc[i], npc: in_npc[i]});
      end else begin
        k = (take < q.size()) ? take : q.size();
        repeat (k) void'(q.pop_front());
        if (exp_ready)
          for (int i = 0; i < n; i++) q.push_back('{inst: in_inst[i], pc: in_pc[i], npc: in_npc[i]});
      end
      if (exp_ready) fetch_pc = fetch_pc + 32'(4 * n);
    end
  endtask

  initial begin
    logic [31:0] prev_pc0;
    reset = 1'b1; squash = 1'b0; in_valid = '0; out_req = '0;
    in_inst = '0; in_pc = '0; in_npc = '0;
    repeat (2) @(posedge clock);

    // Reset mid-operation at count 5 with traffic on the inputs.
    step(0, 0, 2, 0); step(0, 0, 2, 0); step(0, 0, 1, 0);
    step(1, 0, 2, 2);
    step(0, 0, 0, 0);
    check("reset_count", 32'(count), 32'd0);

    // First push of PCs 0 and 4, then fill to full and hold a dropped group.
    fetch_pc = '0;
    step(0, 0, 2, 0);
    for (int c = 0; c < 3; c++) step(0, 0, 2, 0);
    for (int c = 0; c < 3; c++) step(0, 0, 2, 0);
    check("full_count", 32'(count), 32'd8);
    step(0, 0, 0, 2);
    step(0, 0, 0, 0);
    check("after_pop_count", 32'(count), 32'd6);

    // Steady push 2 / pop 2 across pointer wrap; head PC must advance by 8 each cycle.
    step(0, 0, 2, 2);
    prev_pc0 = seen_pc0;
    for (int c = 0; c < 9; c++) begin
      step(0, 0, 2, 2);
      check("wrap_head_pc", seen_pc0, prev_pc0 + 32'd8);
      prev_pc0 = seen_pc0;
    end

    // Squash at count 5 with a push and a pop in the same cycle.
    step(0, 0, 0, 1);
    step(0, 1, 2, 2);
    step(0, 0, 0, 0);
    check("squash_count", 32'(count), 32'd0);

    // Over-pop at count 1, then push 2 with a single pop from empty.
    step(0, 0, 1, 0);
    step(0, 0, 0, 2);
    step(0, 0, 0, 0);
    step(0, 0, 2, 1);
    step(0, 0, 0, 0);

    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, IN_WIDTH), $urandom_range(0, (1 << REQ_W) - 1));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
